// File: rtl/gpio_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gpio_bus_sequencer
// Purpose  : Round-robin arbiter that puts A/C 16-bit words onto the GPIO
//            write bus as two gated w_clk byte strobes, MSB first.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_bus_sequencer #(
    parameter logic [7:0]  A_ADDR      = 8'h00,
    parameter logic [7:0]  C_ADDR      = 8'h01,
    parameter logic [7:0]  IDLE_ADDR   = 8'hFF,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] a_tdata,
    input  logic        a_tvalid,
    output logic        a_tready,
    input  logic [15:0] c_tdata,
    input  logic        c_tvalid,
    output logic        c_tready,
    output logic [31:0] gpio_out,
    output logic        busy,
    output logic [15:0] a_count,
    output logic [15:0] c_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_RELEASE = 3'd3,
        S_LOW     = 3'd4
    } state_t;

    localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_hi;
    logic [15:0] r_word;
    logic        r_last_c;      // doubles as "current word belongs to C" while busy
    logic [15:0] r_a_count;
    logic [15:0] r_c_count;
    logic [31:0] r_gpio;
    logic        r_busy;

    state_t      w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic        w_hi_nxt;
    logic [15:0] w_word_nxt;
    logic        w_last_c_nxt;
    logic        w_a_inc;
    logic        w_c_inc;
    logic        w_grant_a;
    logic        w_grant_c;
    logic        w_idle_en;
    logic        w_done;
    logic [7:0]  w_byte;
    logic [7:0]  w_tgt;
    logic [31:0] w_gpio_nxt;

    always_comb begin
        w_grant_a = a_tvalid & (~c_tvalid | r_last_c);
        w_grant_c = c_tvalid & (~a_tvalid | ~r_last_c);
        w_idle_en = (r_state == S_IDLE) & en;
        a_tready  = w_idle_en & w_grant_a;
        c_tready  = w_idle_en & w_grant_c;
        w_done    = (r_cnt == 8'd0);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_hi_nxt     = r_hi;
        w_word_nxt   = r_word;
        w_last_c_nxt = r_last_c;
        w_a_inc      = 1'b0;
        w_c_inc      = 1'b0;
        if (r_state != S_IDLE && !w_done) begin
            w_cnt_nxt = r_cnt - 8'd1;
        end
        case (r_state)
            S_IDLE: begin
                if (a_tready || c_tready) begin
                    w_word_nxt   = a_tready ? a_tdata : c_tdata;
                    w_last_c_nxt = c_tready;
                    w_hi_nxt     = 1'b1;
                    w_cnt_nxt    = c_HOLD_LAST;
                    w_state_nxt  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_done) begin
                    w_cnt_nxt   = c_HOLD_LAST;
                    w_state_nxt = S_STROBE;
                end
            end
            S_STROBE: begin
                if (w_done) begin
                    w_cnt_nxt   = c_HOLD_LAST;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (w_done) begin
                    w_cnt_nxt   = c_HOLD_LAST;
                    w_state_nxt = S_LOW;
                end
            end
            S_LOW: begin
                if (w_done) begin
                    if (r_hi) begin
                        w_hi_nxt    = 1'b0;
                        w_cnt_nxt   = c_HOLD_LAST;
                        w_state_nxt = S_SETUP;
                    end else begin
                        w_a_inc     = ~r_last_c;
                        w_c_inc     = r_last_c;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bus image is derived from the next state so the registered output
    // lines up with the state it describes.
    always_comb begin
        w_byte = w_hi_nxt ? w_word_nxt[15:8] : w_word_nxt[7:0];
        w_tgt  = w_last_c_nxt ? C_ADDR : A_ADDR;
        case (w_state_nxt)
            S_SETUP:   w_gpio_nxt = {8'h00, IDLE_ADDR, 8'h00, w_byte};
            S_STROBE:  w_gpio_nxt = {8'h80, w_tgt,     8'h00, w_byte};
            S_RELEASE: w_gpio_nxt = {8'h80, IDLE_ADDR, 8'h00, w_byte};
            S_LOW:     w_gpio_nxt = {8'h00, IDLE_ADDR, 8'h00, w_byte};
            default:   w_gpio_nxt = {8'h00, IDLE_ADDR, 16'h0000};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_hi      <= 1'b0;
            r_word    <= 16'h0000;
            r_last_c  <= 1'b1;
            r_a_count <= 16'h0000;
            r_c_count <= 16'h0000;
            r_gpio    <= {8'h00, IDLE_ADDR, 16'h0000};
            r_busy    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hi     <= w_hi_nxt;
            r_word   <= w_word_nxt;
            r_last_c <= w_last_c_nxt;
            r_gpio   <= w_gpio_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            if (w_a_inc) begin
                r_a_count <= r_a_count + 16'd1;
            end
            if (w_c_inc) begin
                r_c_count <= r_c_count + 16'd1;
            end
        end
    end

    assign gpio_out = r_gpio;
    assign busy     = r_busy;
    assign a_count  = r_a_count;
    assign c_count  = r_c_count;

endmodule
`default_nettype wire

// File: tb/tb_gpio_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_bus_sequencer
// Purpose  : Directed bench with a GPIO writer model for two sequencer
//            instances (HOLD_CYCLES = 4 and HOLD_CYCLES = 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_bus_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, a_tvalid, a_tready, c_tvalid, c_tready, busy;
    logic [15:0] a_tdata, c_tdata, a_count, c_count;
    logic [31:0] gpio_out;

    logic        rst1, en1, a1_tvalid, a1_tready, c1_tvalid, c1_tready, busy1;
    logic [15:0] a1_tdata, c1_tdata, a1_count, c1_count;
    logic [31:0] gpio1;

    gpio_bus_sequencer dut (
        .clk(clk), .rst(rst), .en(en),
        .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready),
        .c_tdata(c_tdata), .c_tvalid(c_tvalid), .c_tready(c_tready),
        .gpio_out(gpio_out), .busy(busy), .a_count(a_count), .c_count(c_count)
    );

    gpio_bus_sequencer #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst1), .en(en1),
        .a_tdata(a1_tdata), .a_tvalid(a1_tvalid), .a_tready(a1_tready),
        .c_tdata(c1_tdata), .c_tvalid(c1_tvalid), .c_tready(c1_tready),
        .gpio_out(gpio1), .busy(busy1), .a_count(a1_count), .c_count(c1_count)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Writer model: a byte is captured when w_clk=1 with a fifo address first
    // appears; consecutive bytes per address pair into {ch, word}.
    logic [31:0] mon_g   [2];
    logic        mon_rst [2];
    logic        prev_cap[2];
    logic [7:0]  prev_ad [2];
    logic        have_hi [4];
    logic [7:0]  hi_b    [4];
    int          viol    [2];
    logic [16:0] got0[$];
    logic [16:0] got1[$];
    logic [16:0] exp0[$];
    logic [16:0] exp1[$];
    logic [7:0]  mon_ad, mon_dat;
    logic        mon_cap, mon_tgt;
    int          mon_k;

    assign mon_g[0]   = gpio_out;
    assign mon_g[1]   = gpio1;
    assign mon_rst[0] = rst;
    assign mon_rst[1] = rst1;

    initial begin
        for (int i = 0; i < 2; i++) begin
            viol[i] = 0; prev_cap[i] = 1'b0; prev_ad[i] = 8'hFF;
        end
        for (int i = 0; i < 4; i++) begin
            have_hi[i] = 1'b0; hi_b[i] = 8'h00;
        end
    end

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            mon_ad  = mon_g[d][23:16];
            mon_dat = mon_g[d][7:0];
            mon_tgt = (mon_ad == 8'h00) || (mon_ad == 8'h01);
            mon_cap = mon_g[d][31] && mon_tgt;
            if (mon_rst[d]) begin
                prev_cap[d] = 1'b0;
                prev_ad[d]  = 8'hFF;
                have_hi[2*d] = 1'b0;
                have_hi[2*d+1] = 1'b0;
            end else begin
                if (mon_tgt && !mon_g[d][31]) viol[d]++;
                if (mon_cap && !(prev_cap[d] && prev_ad[d] == mon_ad)) begin
                    mon_k = 2*d + int'(mon_ad[0]);
                    if (!have_hi[mon_k]) begin
                        hi_b[mon_k]    = mon_dat;
                        have_hi[mon_k] = 1'b1;
                    end else begin
                        have_hi[mon_k] = 1'b0;
                        if (d == 0) got0.push_back({mon_ad[0], hi_b[mon_k], mon_dat});
                        else        got1.push_back({mon_ad[0], hi_b[mon_k], mon_dat});
                    end
                end
                prev_cap[d] = mon_cap;
                prev_ad[d]  = mon_ad;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic words0(input string tag);
        chk({tag, "_nwords"}, 32'(got0.size()), 32'(exp0.size()));
        for (int i = 0; i < exp0.size(); i++)
            if (i < got0.size()) chk(tag, 32'(got0[i]), 32'(exp0[i]));
    endtask

    task automatic words1(input string tag);
        chk({tag, "_nwords"}, 32'(got1.size()), 32'(exp1.size()));
        for (int i = 0; i < exp1.size(); i++)
            if (i < got1.size()) chk(tag, 32'(got1[i]), 32'(exp1[i]));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; a_tvalid = 1'b0; c_tvalid = 1'b0;
        a_tdata = 16'h0000; c_tdata = 16'h0000;
        rst1 = 1'b1; en1 = 1'b1; a1_tvalid = 1'b0; c1_tvalid = 1'b0;
        a1_tdata = 16'h0000; c1_tdata = 16'h0000;

        // Reset
        cyc(2);
        rst = 1'b0; rst1 = 1'b0;
        cyc(1);
        chk("rst_gpio", gpio_out, 32'h00FF0000);
        chk("rst_busy", busy, 0);
        chk("rst_a_tready", a_tready, 0);
        chk("rst_c_tready", c_tready, 0);
        chk("rst_a_count", a_count, 0);
        chk("rst_c_count", c_count, 0);
        chk("rst1_gpio", gpio1, 32'h00FF0000);

        // Single A word 16'hBEEF
        a_tdata = 16'hBEEF; a_tvalid = 1'b1;
        #1 chk("beef_ready", a_tready, 1);
        exp0.push_back({1'b0, 16'hBEEF});
        cyc(1);
        chk("beef_busy", busy, 1);
        chk("beef_setup_hi", gpio_out, 32'h00FF00BE);
        chk("beef_ready_drop", a_tready, 0);
        a_tvalid = 1'b0;
        cyc(4); chk("beef_strobe_hi_first", gpio_out, 32'h800000BE);
        cyc(3); chk("beef_strobe_hi_last", gpio_out, 32'h800000BE);
        cyc(1); chk("beef_release_hi", gpio_out, 32'h80FF00BE);
        cyc(4); chk("beef_low_hi", gpio_out, 32'h00FF00BE);
        cyc(4); chk("beef_setup_lo", gpio_out, 32'h00FF00EF);
        cyc(4); chk("beef_strobe_lo", gpio_out, 32'h800000EF);
        cyc(4); chk("beef_release_lo", gpio_out, 32'h80FF00EF);
        cyc(7);
        chk("beef_count_before", a_count, 0);
        chk("beef_busy_last", busy, 1);
        cyc(1);
        chk("beef_count", a_count, 1);
        chk("beef_idle_busy", busy, 0);
        chk("beef_idle_gpio", gpio_out, 32'h00FF0000);
        words0("beef_word");

        // Round-robin from a fresh reset: A, C, A, C
        rst = 1'b1; cyc(1); rst = 1'b0; cyc(1);
        a_tdata = 16'h1111; c_tdata = 16'h2222;
        a_tvalid = 1'b1; c_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_a_ready", a_tready, (i % 2 == 0) ? 1 : 0);
            chk("rr_c_ready", c_tready, (i % 2 == 1) ? 1 : 0);
            if (i % 2 == 0) exp0.push_back({1'b0, 16'h1111});
            else            exp0.push_back({1'b1, 16'h2222});
            cyc(1);
            chk("rr_busy", busy, 1);
            if (i == 3) begin
                a_tvalid = 1'b0; c_tvalid = 1'b0;
            end
            cyc(31);
            chk("rr_no_early_grant", {a_tready, c_tready}, 0);
            cyc(1);
        end
        chk("rr_a_count", a_count, 2);
        chk("rr_c_count", c_count, 2);
        words0("rr_word");

        // en gating during a C word with an A word waiting
        c_tdata = 16'h3456; c_tvalid = 1'b1;
        #1 chk("en_c_ready", c_tready, 1);
        exp0.push_back({1'b1, 16'h3456});
        cyc(1);
        c_tvalid = 1'b0; en = 1'b0;
        a_tdata = 16'hABCD; a_tvalid = 1'b1;
        #1 chk("en_a_blocked_busy", a_tready, 0);
        cyc(32);
        chk("en_c_count", c_count, 3);
        chk("en_idle_busy", busy, 0);
        chk("en_a_blocked_idle", a_tready, 0);
        cyc(3);
        chk("en_still_blocked", {a_tready, c_tready}, 0);
        chk("en_still_idle", busy, 0);
        en = 1'b1;
        #1 chk("en_a_ready", a_tready, 1);
        exp0.push_back({1'b0, 16'hABCD});
        cyc(1);
        chk("en_a_busy", busy, 1);
        chk("en_a_setup", gpio_out, 32'h00FF00AB);
        a_tvalid = 1'b0;
        cyc(32);
        chk("en_a_count", a_count, 3);
        words0("en_word");

        // Reset during the low-byte STROBE; held word is re-accepted
        a_tdata = 16'hC3A5; a_tvalid = 1'b1;
        #1 chk("rm_ready", a_tready, 1);
        exp0.push_back({1'b0, 16'hC3A5});
        cyc(22);
        chk("rm_strobe_lo", gpio_out, 32'h800000A5);
        rst = 1'b1;
        cyc(1);
        chk("rm_gpio", gpio_out, 32'h00FF0000);
        chk("rm_busy", busy, 0);
        chk("rm_a_count", a_count, 0);
        chk("rm_c_count", c_count, 0);
        rst = 1'b0;
        #1 chk("rm_reaccept", a_tready, 1);
        exp0.push_back({1'b0, 16'hC3A5});
        cyc(1);
        chk("rm_setup", gpio_out, 32'h00FF00C3);
        a_tvalid = 1'b0;
        cyc(32);
        chk("rm_a_count_after", a_count, 1);
        words0("rm_word");

        // HOLD_CYCLES=1: 9-cycle word period and count wrap
        dut1.r_a_count = 16'hFFFE;
        #1 chk("h1_preload", a1_count, 16'hFFFE);
        a1_tdata = 16'h7E81; a1_tvalid = 1'b1;
        #1 chk("h1_ready", a1_tready, 1);
        exp1.push_back({1'b0, 16'h7E81});
        cyc(1); chk("h1_setup_hi", gpio1, 32'h00FF007E);
        cyc(1); chk("h1_strobe_hi", gpio1, 32'h8000007E);
        cyc(1); chk("h1_release_hi", gpio1, 32'h80FF007E);
        cyc(3); chk("h1_strobe_lo", gpio1, 32'h80000081);
        cyc(2);
        chk("h1_count_hold", a1_count, 16'hFFFE);
        chk("h1_busy", busy1, 1);
        cyc(1);
        chk("h1_count_ffff", a1_count, 16'hFFFF);
        chk("h1_idle", busy1, 0);
        #1 chk("h1_ready2", a1_tready, 1);
        exp1.push_back({1'b0, 16'h7E81});
        cyc(9);
        chk("h1_count_wrap", a1_count, 16'h0000);
        chk("h1_idle2", busy1, 0);
        a1_tvalid = 1'b0;
        cyc(2);
        words1("h1_word");

        chk("addr_gate_dut", 32'(viol[0]), 0);
        chk("addr_gate_dut1", 32'(viol[1]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
